// File: rtl/mem_write_buffer_if.sv
// Request/response types shared by the cache, the write buffer and backing memory,
// plus the bundled port interface of mem_write_buffer.
package mem_write_buffer_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  do_read;
      logic [3:0]  do_write;
      logic        valid;
      logic [3:0]  user_tag;
   } memory_io_req;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        valid;
      logic        ready;
      logic [3:0]  user_tag;
      logic        dummy;
   } memory_io_rsp;

   localparam memory_io_req memory_io_no_req = '0;

   typedef enum logic [1:0] {
      M_IDLE       = 2'd0,
      M_WRITE_WAIT = 2'd1,
      M_READ_WAIT  = 2'd2
   } mem_state_t;

endpackage

interface mem_write_buffer_if;
   import mem_write_buffer_pkg::*;

   // Handshake: a cache request transfers on a rising edge where cache_req.valid and
   // cache_rsp.ready are both 1 (valid while ready=0 is dropped, not held). cache_rsp.valid,
   // mem_req.valid and mem_rsp.valid are single-cycle pulses with no backpressure.
   memory_io_req cache_req;
   memory_io_rsp cache_rsp;
   memory_io_req mem_req;
   memory_io_rsp mem_rsp;
   logic         empty;
   mem_state_t   dbg_state;

   modport slave (
      input  cache_req,
      input  mem_rsp,
      output cache_rsp,
      output mem_req,
      output empty,
      output dbg_state
   );

   modport master (
      output cache_req,
      output mem_rsp,
      input  cache_rsp,
      input  mem_req,
      input  empty,
      input  dbg_state
   );

endinterface

// File: rtl/mem_write_buffer.sv
// Posted-write buffer: writes are acked once queued and drain to memory in order;
// reads bypass the queue unless they alias a buffered word.
module mem_write_buffer
   import mem_write_buffer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input logic               clk,
   input logic               reset,
   mem_write_buffer_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic             slot_valid;
   logic [31:0]      slot_addr;
   logic [31:0]      slot_data;
   logic [3:0]       slot_do_read;
   logic [3:0]       slot_do_write;
   logic [3:0]       slot_tag;

   logic [31:0]      fifo_addr     [DEPTH];
   logic [31:0]      fifo_data     [DEPTH];
   logic [3:0]       fifo_do_write [DEPTH];
   logic [3:0]       fifo_tag      [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   mem_state_t       state;
   mem_state_t       state_nx;
   logic             issue_rd;
   logic             issue_wr;
   logic             pop;
   logic             rd_done;
   logic             enq;
   logic             hazard;
   logic             slot_is_write;

   logic             rsp_valid;
   logic [31:0]      rsp_addr;
   logic [31:0]      rsp_data;
   logic [3:0]       rsp_tag;
   memory_io_req     mem_req_q;

   assign slot_is_write = (slot_do_write != 4'h0);
   // Fullness is judged before any same-cycle pop, so a full FIFO costs the slot one extra cycle.
   assign enq = slot_valid && slot_is_write && (count < CNT_W'(DEPTH));

   // The in-flight head stays inside [rd_ptr, rd_ptr+count) until its ack, so it is compared too.
   always_comb begin : hazard_scan
      logic [PTR_W-1:0] ofs;
      hazard = 1'b0;
      ofs    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ofs = PTR_W'(i) - rd_ptr;
         if (({1'b0, ofs} < count) && (fifo_addr[i][31:2] == slot_addr[31:2])) begin
            hazard = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      issue_rd = 1'b0;
      issue_wr = 1'b0;
      pop      = 1'b0;
      rd_done  = 1'b0;
      case (state)
         M_IDLE: begin
            if (slot_valid && !slot_is_write && !hazard) begin
               issue_rd = 1'b1;
               state_nx = M_READ_WAIT;
            end else if (count != '0) begin
               issue_wr = 1'b1;
               state_nx = M_WRITE_WAIT;
            end
         end
         M_WRITE_WAIT: begin
            if (bus.mem_rsp.valid) begin
               pop      = 1'b1;
               state_nx = M_IDLE;
            end
         end
         M_READ_WAIT: begin
            if (bus.mem_rsp.valid) begin
               rd_done  = 1'b1;
               state_nx = M_IDLE;
            end
         end
         default: state_nx = M_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= M_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_addr[wr_ptr]     <= slot_addr;
         fifo_data[wr_ptr]     <= slot_data;
         fifo_do_write[wr_ptr] <= slot_do_write;
         fifo_tag[wr_ptr]      <= slot_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         slot_valid    <= 1'b0;
         slot_addr     <= '0;
         slot_data     <= '0;
         slot_do_read  <= '0;
         slot_do_write <= '0;
         slot_tag      <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         rsp_valid     <= 1'b0;
         rsp_addr      <= '0;
         rsp_data      <= '0;
         rsp_tag       <= '0;
         mem_req_q     <= memory_io_no_req;
      end else begin
         mem_req_q <= memory_io_no_req;
         rsp_valid <= 1'b0;

         if (bus.cache_req.valid && !slot_valid) begin
            slot_valid    <= 1'b1;
            slot_addr     <= bus.cache_req.addr;
            slot_data     <= bus.cache_req.data;
            slot_do_read  <= bus.cache_req.do_read;
            slot_do_write <= bus.cache_req.do_write;
            slot_tag      <= bus.cache_req.user_tag;
         end

         if (enq) begin
            wr_ptr     <= wr_ptr + PTR_W'(1);
            slot_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_addr   <= slot_addr;
            rsp_data   <= slot_data;
            rsp_tag    <= slot_tag;
         end

         if (rd_done) begin
            slot_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_addr   <= slot_addr;
            rsp_data   <= bus.mem_rsp.data;
            rsp_tag    <= slot_tag;
         end

         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end

         if (issue_rd) begin
            mem_req_q.valid    <= 1'b1;
            mem_req_q.addr     <= slot_addr;
            mem_req_q.do_read  <= slot_do_read;
            mem_req_q.user_tag <= slot_tag;
         end

         if (issue_wr) begin
            mem_req_q.valid    <= 1'b1;
            mem_req_q.addr     <= fifo_addr[rd_ptr];
            mem_req_q.data     <= fifo_data[rd_ptr];
            mem_req_q.do_write <= fifo_do_write[rd_ptr];
            mem_req_q.user_tag <= fifo_tag[rd_ptr];
         end

         case ({enq, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      bus.cache_rsp          = '0;
      bus.cache_rsp.addr     = rsp_addr;
      bus.cache_rsp.data     = rsp_data;
      bus.cache_rsp.valid    = rsp_valid;
      bus.cache_rsp.ready    = !slot_valid;
      bus.cache_rsp.user_tag = rsp_tag;
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.empty     = (count == '0) && (state != M_WRITE_WAIT);
   assign bus.dbg_state = state;

   // Backing memory only supplies valid and data.
   logic unused_rsp_bits;
   assign unused_rsp_bits = ^{bus.mem_rsp.addr, bus.mem_rsp.ready, bus.mem_rsp.user_tag,
                              bus.mem_rsp.dummy};

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Posted-write buffer between the cache's memory port and backing memory. It accepts the cache's word-granular `memory_io_req` traffic and acknowledges writes as soon as they are queued. Buffered writes drain to memory in FIFO order. Reads bypass the queue unless they alias a buffered word, in which case they wait for the queue to drain.

## Interface
- `DEPTH`, 8: write FIFO entries; power of two, ≥2.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low. Asserted when 0 and sampled on `clk`.
- `cache_req` in `memory_io_req`: request from the cache (`addr`, `data`, `do_read`, `do_write`, `valid`, `user_tag`).
- `cache_rsp` out `memory_io_rsp`: response to the cache (`addr`, `data`, `valid`, `ready`, `user_tag`; `dummy`=0).
- `mem_req` out `memory_io_req`: request to backing memory.
- `mem_rsp` in `memory_io_rsp`: response from backing memory; only `valid` and `data` are used.
- `empty` out 1: FIFO holds no entries and no write is in flight.

## Operation
- **Request slot.** A single register holds `addr`, `data`, `do_write`, `user_tag` and `slot_valid`.
  - `cache_rsp.ready = !slot_valid`.
  - The slot is loaded when `cache_req.valid && ready`. `cache_req.valid` while `ready=0` is ignored.
- **Classification.** `do_write != 0` makes the request a write. Anything else is a read; `do_read` is forwarded unchanged.
- **Slot write, FIFO not full** (count<DEPTH, evaluated before any same-cycle pop):
  - Enqueue {addr, data, do_write, user_tag}.
  - Clear the slot.
  - Register `cache_rsp` with valid=1, addr=slot addr, data=slot data, user_tag=slot tag.
- **Slot write, FIFO full.** The slot holds and `ready` stays 0 until a pop frees an entry.
- **Hazard.** A slot read hazards if `addr[31:2]` equals `addr[31:2]` of any valid FIFO entry. The in-flight head counts, because it is popped only on its ack.
- **Memory-port FSM.** States are M_IDLE, M_WRITE_WAIT, M_READ_WAIT. At most one memory transaction is outstanding.
  - **M_IDLE, slot holds a non-hazard read:** issue `mem_req` with the slot's addr, do_read, user_tag, data=0, do_write=0, then go to M_READ_WAIT. Reads have priority over draining.
  - **M_IDLE, otherwise, FIFO non-empty:** issue the head entry with do_read=0 and its do_write, then go to M_WRITE_WAIT.
  - **M_WRITE_WAIT, on `mem_rsp.valid`:** pop the head (pointer wraps mod DEPTH) and go to M_IDLE.
  - **M_READ_WAIT, on `mem_rsp.valid`:** register `cache_rsp` with valid=1, data=`mem_rsp.data`, addr and user_tag from the slot. Clear the slot and go to M_IDLE.
- A hazarded read waits in the slot while the FIFO drains, then issues once no match remains.
- `mem_rsp.valid` in M_IDLE is ignored.
- **Count and pointers.** The count is `$clog2(DEPTH)+1` bits. Enqueue and pop may occur in the same cycle; the count is then unchanged.

## Timing
- `mem_req` and `cache_rsp.valid` are registered. Each is valid for exactly one cycle per transaction.
- `mem_req` is `memory_io_no_req` whenever it is not pulsing.
- **Write ack latency.** Request accepted at cycle 0 → slot at cycle 1 → `cache_rsp.valid` at cycle 2. This holds when the FIFO is not full.
- **Read latency.**
  - Request at cycle 0 → `mem_req.valid` at cycle 2 at the earliest (memory idle, no hazard).
  - `mem_rsp.valid` at cycle k → `cache_rsp.valid` at k+1.
  - `ready` returns at k+1.
- **Drain.** The FSM leaves M_IDLE for M_WRITE_WAIT and the entry's `mem_req` pulse follows on the next cycle. After each ack the FSM re-enters M_IDLE for one cycle before the next issue. Minimum spacing between successive write issues is therefore 3 cycles plus memory latency.
- **Reset values (`reset`=0 at a rising edge):**
  - `cache_rsp`: valid=0, ready=1, addr/data/user_tag=0.
  - `mem_req` = `memory_io_no_req`.
  - `empty`=1.
  - FIFO count and pointers cleared, slot cleared, FSM in M_IDLE.
- **Reset mid-operation.** The in-flight memory transaction is abandoned and a later `mem_rsp.valid` is ignored. Buffered writes are discarded.

## Test plan
- **Reset.** Hold `reset`=0 for 2 cycles, then release → `ready`=1, `empty`=1, no `mem_req.valid`, no `cache_rsp.valid`.
- **Posted write.** Write addr 0x100, data 0xDEADBEEF, do_write=4'b1111, tag 3 → `cache_rsp` valid at cycle 2 with addr 0x100, tag 3. Then `mem_req` write to 0x100 with 0xDEADBEEF. On the memory ack `empty` returns to 1.
- **Fill to full.** Memory stalls `mem_rsp` and 9 writes are issued with DEPTH=8 → 8 acks. On the 9th, `ready` stays 0 until the first memory ack, then the 9th ack follows.
- **Read bypass.** Queue 3 writes to 0x200–0x208, then read 0x300 → the read's `mem_req` issues before the remaining queued writes. `cache_rsp.data` equals the `mem_rsp.data` returned.
- **Read hazard.** Queue a write to 0x204, then read 0x206 → no read `mem_req` until the 0x204 write is acked. The read issues afterward.
- **Reset during M_READ_WAIT.** Assert reset, then deliver `mem_rsp.valid` → no `cache_rsp.valid`, FSM stays in M_IDLE, `empty`=1.
